// File: rtl/operand_bram_sequencer_pkg.sv
// Shared definitions for the calculator operand path: sequencer state
// encoding, operand BRAM address map and the ALU operation codes.
package operand_bram_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_OP,
      ST_RD_A,
      ST_WAIT_A,
      ST_RD_B,
      ST_WAIT_B,
      ST_EXEC,
      ST_WAIT_ALU,
      ST_WR_RES
   } seq_state_t;

   localparam logic [1:0] ADDR_A   = 2'd0;
   localparam logic [1:0] ADDR_B   = 2'd1;
   localparam logic [1:0] ADDR_RES = 2'd2;

   // Operation codes, shared with the ALU and the input editor.
   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } alu_op_t;

endpackage

// File: rtl/operand_bram_sequencer_alu_watchdog.sv
// Cycle counter guarding the ALU handshake. Cleared while the ALU is being
// started, counts while enabled, and flags the last allowed waiting cycle
// so the sequencer leaves WAIT_ALU after exactly TIMEOUT cycles there.
module alu_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   // Saturating up-count while enabled; clear has priority.
   always_comb begin
      cnt_next = cnt_reg;
      if (clear) begin
         cnt_next = '0;
      end else if (enable && (cnt_reg != CNT_W'(TIMEOUT))) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   // High during the TIMEOUT-th enabled cycle; the FSM aborts on it.
   assign timeout = enable && (cnt_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/operand_bram_sequencer.sv
// Owner of the single-port operand BRAM. Serves operand writes from the
// input editor and runs compute requests: read A, read B, start the ALU,
// wait for it (with watchdog) and write the result back to address 2.
module operand_bram_sequencer
   import operand_bram_sequencer_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int RD_LAT  = 1,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              store_req,
   input  logic              store_sel,
   input  logic [DATA_W-1:0] store_data,
   output logic              store_ack,
   input  logic              go,
   input  logic [1:0]        op,
   output logic              bram_en,
   output logic              bram_we,
   output logic [1:0]        bram_addr,
   output logic [DATA_W-1:0] bram_din,
   input  logic [DATA_W-1:0] bram_dout,
   output logic              alu_start,
   output logic [1:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic              alu_done,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_err,
   output logic              busy,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              err
);

   seq_state_t        state_reg;
   seq_state_t        state_next;
   logic              go_pending_reg;
   alu_op_t           op_reg;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] res_hold_reg;
   logic [DATA_W-1:0] result_reg;
   logic              result_valid_reg;
   logic              err_reg;
   logic [1:0]        lat_cnt_reg;
   logic              lat_last;
   logic              wd_clear;
   logic              wd_enable;
   logic              wd_timeout;

   // Last cycle of a WAIT_A/WAIT_B window: read data is on bram_dout now.
   assign lat_last = (lat_cnt_reg == 2'(RD_LAT - 1));

   alu_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .timeout (wd_timeout)
   );

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and BRAM/ALU strobes decoded from the current state.
   always_comb begin
      state_next = state_reg;
      bram_en    = 1'b0;
      bram_we    = 1'b0;
      bram_addr  = ADDR_A;
      bram_din   = '0;
      store_ack  = 1'b0;
      alu_start  = 1'b0;
      wd_clear   = 1'b0;
      wd_enable  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // A waiting store always wins over a compute request.
            if (store_req) begin
               state_next = ST_WR_OP;
            end else if (go || go_pending_reg) begin
               state_next = ST_RD_A;
            end
         end
         ST_WR_OP: begin
            bram_en    = 1'b1;
            bram_we    = 1'b1;
            bram_addr  = {1'b0, store_sel};
            bram_din   = store_data;
            store_ack  = 1'b1;
            state_next = ST_IDLE;
         end
         ST_RD_A: begin
            bram_en    = 1'b1;
            bram_addr  = ADDR_A;
            state_next = ST_WAIT_A;
         end
         ST_WAIT_A: begin
            if (lat_last) state_next = ST_RD_B;
         end
         ST_RD_B: begin
            bram_en    = 1'b1;
            bram_addr  = ADDR_B;
            state_next = ST_WAIT_B;
         end
         ST_WAIT_B: begin
            if (lat_last) state_next = ST_EXEC;
         end
         ST_EXEC: begin
            alu_start  = 1'b1;
            wd_clear   = 1'b1;
            state_next = ST_WAIT_ALU;
         end
         ST_WAIT_ALU: begin
            wd_enable = 1'b1;
            // A done in the final allowed cycle still counts as an answer.
            if (alu_done) begin
               state_next = alu_err ? ST_IDLE : ST_WR_RES;
            end else if (wd_timeout) begin
               state_next = ST_IDLE;
            end
         end
         ST_WR_RES: begin
            bram_en    = 1'b1;
            bram_we    = 1'b1;
            bram_addr  = ADDR_RES;
            bram_din   = res_hold_reg;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath: request bookkeeping, operand capture and result/status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         go_pending_reg   <= 1'b0;
         op_reg           <= OP_ADD;
         a_reg            <= '0;
         b_reg            <= '0;
         res_hold_reg     <= '0;
         result_reg       <= '0;
         result_valid_reg <= 1'b0;
         err_reg          <= 1'b0;
         lat_cnt_reg      <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (store_req) begin
                  if (go) begin
                     go_pending_reg <= 1'b1;
                     op_reg         <= alu_op_t'(op);
                  end
               end else if (go || go_pending_reg) begin
                  go_pending_reg   <= 1'b0;
                  result_valid_reg <= 1'b0;
                  err_reg          <= 1'b0;
                  if (go) op_reg <= alu_op_t'(op);
               end
            end
            ST_WR_OP: begin
               if (go) begin
                  go_pending_reg <= 1'b1;
                  op_reg         <= alu_op_t'(op);
               end
            end
            ST_RD_A, ST_RD_B: begin
               lat_cnt_reg <= '0;
            end
            ST_WAIT_A: begin
               lat_cnt_reg <= lat_cnt_reg + 2'd1;
               if (lat_last) a_reg <= bram_dout;
            end
            ST_WAIT_B: begin
               lat_cnt_reg <= lat_cnt_reg + 2'd1;
               if (lat_last) b_reg <= bram_dout;
            end
            ST_WAIT_ALU: begin
               if (alu_done) begin
                  if (alu_err) err_reg <= 1'b1;
                  else         res_hold_reg <= alu_result;
               end else if (wd_timeout) begin
                  err_reg <= 1'b1;
               end
            end
            ST_WR_RES: begin
               result_reg       <= res_hold_reg;
               result_valid_reg <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy         = (state_reg != ST_IDLE);
   assign alu_op       = op_reg;
   assign alu_a        = a_reg;
   assign alu_b        = b_reg;
   assign result       = result_reg;
   assign result_valid = result_valid_reg;
   assign err          = err_reg;

endmodule

// File: tb/tb_operand_bram_sequencer.sv
// Directed plus randomized bench for operand_bram_sequencer. A behavioural
// BRAM and an ALU stub surround the DUT; expected BRAM contents, results
// and flags come from a small reference model kept here.
module tb_operand_bram_sequencer;
   import operand_bram_sequencer_pkg::*;

   localparam int DATA_W  = 16;
   localparam int RD_LAT  = 1;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              store_req;
   logic              store_sel;
   logic [DATA_W-1:0] store_data;
   logic              store_ack;
   logic              go;
   logic [1:0]        op;
   logic              bram_en;
   logic              bram_we;
   logic [1:0]        bram_addr;
   logic [DATA_W-1:0] bram_din;
   logic [DATA_W-1:0] bram_dout;
   logic              alu_start;
   logic [1:0]        alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic              alu_done;
   logic [DATA_W-1:0] alu_result;
   logic              alu_err;
   logic              busy;
   logic [DATA_W-1:0] result;
   logic              result_valid;
   logic              err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DATA_W-1:0] exp_mem [0:2];
   logic [DATA_W-1:0] exp_result;
   logic              exp_valid;
   logic              exp_err;

   always #5 clk = ~clk;

   operand_bram_sequencer #(
      .DATA_W  (DATA_W),
      .RD_LAT  (RD_LAT),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .store_req    (store_req),
      .store_sel    (store_sel),
      .store_data   (store_data),
      .store_ack    (store_ack),
      .go           (go),
      .op           (op),
      .bram_en      (bram_en),
      .bram_we      (bram_we),
      .bram_addr    (bram_addr),
      .bram_din     (bram_din),
      .bram_dout    (bram_dout),
      .alu_start    (alu_start),
      .alu_op       (alu_op),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_done     (alu_done),
      .alu_result   (alu_result),
      .alu_err      (alu_err),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .err          (err)
   );

   // Behavioural single-port BRAM with RD_LAT read latency
   logic [DATA_W-1:0] bram_mem [0:3];
   logic [DATA_W-1:0] rd_pipe  [0:RD_LAT-1];
   logic              mem_clr;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 4; i++) bram_mem[i] <= '0;
      end else if (bram_en && bram_we) begin
         bram_mem[bram_addr] <= bram_din;
      end
      if (bram_en) rd_pipe[0] <= bram_mem[bram_addr];
      for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign bram_dout = rd_pipe[RD_LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < 3; i++)
         chk($sformatf("%s_mem%0d", tag, i), 32'(bram_mem[i]), 32'(exp_mem[i]));
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_result"}, 32'(result), 32'(exp_result));
      chk({tag, "_valid"},  32'(result_valid), 32'(exp_valid));
      chk({tag, "_err"},    32'(err), 32'(exp_err));
   endtask

   // ALU stub behaviour: {err, value}
   function automatic logic [DATA_W:0] alu_ref(input logic [1:0] o,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] r;
      logic              e;
      e = 1'b0;
      case (o)
         2'd0:    r = a + b;
         2'd1:    r = a - b;
         2'd2:    r = DATA_W'(a * b);
         default: begin
            if (b == '0) begin r = '0; e = 1'b1; end
            else r = a / b;
         end
      endcase
      return {e, r};
   endfunction

   // Operand write starting from an IDLE cycle (store_req may already be held).
   task automatic do_store(input logic sel, input logic [DATA_W-1:0] data);
      store_req = 1'b1; store_sel = sel; store_data = data;
      tick;
      chk("st_ack",  32'(store_ack), 1);
      chk("st_we",   32'(bram_we), 1);
      chk("st_addr", 32'(bram_addr), 32'(sel));
      chk("st_din",  32'(bram_din), 32'(data));
      store_req = 1'b0;
      exp_mem[sel] = data;
      tick;
      chk("st_idle", 32'(busy), 0);
      $display("store sel=%0d data=%h", sel, data);
   endtask

   // One compute transaction from IDLE, with optional variants.
   task automatic compute(input logic [1:0] opc, input int delay, input bit force_err,
                          input bit silent, input bit simul, input logic [DATA_W-1:0] sim_b,
                          input bit hold_st, input logic hold_sel,
                          input logic [DATA_W-1:0] hold_data);
      logic [DATA_W:0]   ref_out;
      logic [DATA_W-1:0] res;
      bit                aerr;
      if (simul) begin
         store_req = 1'b1; store_sel = 1'b1; store_data = sim_b; go = 1'b1; op = opc;
         tick;
         go = 1'b0;
         chk("sim_ack",  32'(store_ack), 1);
         chk("sim_addr", 32'(bram_addr), 1);
         chk("sim_din",  32'(bram_din), 32'(sim_b));
         store_req = 1'b0;
         exp_mem[1] = sim_b;
         tick;
         chk("sim_pend_idle", 32'(busy), 0);
         tick;
      end else begin
         go = 1'b1; op = opc;
         tick;
         go = 1'b0;
      end
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      // RD_A
      chk("rda_en",   32'(bram_en), 1);
      chk("rda_we",   32'(bram_we), 0);
      chk("rda_addr", 32'(bram_addr), 0);
      chk("rda_busy", 32'(busy), 1);
      if (hold_st) begin
         store_req = 1'b1; store_sel = hold_sel; store_data = hold_data;
      end
      repeat (RD_LAT + 1) tick;
      // RD_B
      chk("rdb_en",   32'(bram_en), 1);
      chk("rdb_addr", 32'(bram_addr), 1);
      chk("rdb_ack",  32'(store_ack), 0);
      repeat (RD_LAT + 1) tick;
      // EXEC
      chk("exec_start", 32'(alu_start), 1);
      chk("exec_a",     32'(alu_a), 32'(exp_mem[0]));
      chk("exec_b",     32'(alu_b), 32'(exp_mem[1]));
      chk("exec_op",    32'(alu_op), 32'(opc));
      ref_out = alu_ref(opc, exp_mem[0], exp_mem[1]);
      res  = ref_out[DATA_W-1:0];
      aerr = force_err || ref_out[DATA_W];
      tick;
      chk("walu_start", 32'(alu_start), 0);
      if (silent) begin
         repeat (TIMEOUT - 1) begin
            chk("wd_busy", 32'(busy), 1);
            tick;
         end
         chk("wd_last_busy", 32'(busy), 1);
         chk("wd_last_err",  32'(err), 0);
         tick;
         exp_err = 1'b1;
         chk("wd_busy_fall", 32'(busy), 0);
         chk("wd_we",        32'(bram_we), 0);
         check_status("wd");
         // Late answer must be ignored
         alu_done = 1'b1; alu_err = 1'b0; alu_result = DATA_W'($urandom);
         tick;
         alu_done = 1'b0;
         chk("late_busy", 32'(busy), 0);
         chk("late_we",   32'(bram_we), 0);
         tick;
         check_status("late");
         $display("compute op=%0d timeout err=%0d", opc, err);
      end else begin
         repeat (delay) begin
            chk("walu_busy", 32'(busy), 1);
            chk("walu_ack",  32'(store_ack), 0);
            tick;
         end
         alu_done = 1'b1; alu_result = res; alu_err = aerr;
         tick;
         alu_done = 1'b0; alu_err = 1'b0; alu_result = DATA_W'($urandom);
         if (!aerr) begin
            chk("wr_en",   32'(bram_en), 1);
            chk("wr_we",   32'(bram_we), 1);
            chk("wr_addr", 32'(bram_addr), 2);
            chk("wr_din",  32'(bram_din), 32'(res));
            chk("wr_ack",  32'(store_ack), 0);
            tick;
            exp_mem[2] = res;
            exp_result = res;
            exp_valid  = 1'b1;
            chk("done_busy", 32'(busy), 0);
            check_status("done");
         end else begin
            exp_err = 1'b1;
            chk("aerr_busy", 32'(busy), 0);
            chk("aerr_we",   32'(bram_we), 0);
            check_status("aerr");
         end
         $display("compute op=%0d a=%h b=%h delay=%0d err=%0d result=%h valid=%0d",
                  opc, exp_mem[0], exp_mem[1], delay, err, result, result_valid);
      end
   endtask

   initial begin
      logic [1:0] r_op;
      int         r_dly;
      bit         r_err;

      reset = 1'b1; mem_clr = 1'b1;
      store_req = 1'b0; store_sel = 1'b0; store_data = '0;
      go = 1'b0; op = 2'd0;
      alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
      for (int i = 0; i < 3; i++) exp_mem[i] = '0;
      exp_result = '0; exp_valid = 1'b0; exp_err = 1'b0;
      tick;
      tick;
      // Reset state
      chk("rst_busy",  32'(busy), 0);
      chk("rst_en",    32'(bram_en), 0);
      chk("rst_we",    32'(bram_we), 0);
      chk("rst_ack",   32'(store_ack), 0);
      chk("rst_start", 32'(alu_start), 0);
      chk("rst_a",     32'(alu_a), 0);
      check_status("rst");
      reset = 1'b0; mem_clr = 1'b0;
      tick;

      // Store then compute: 100 + 25
      do_store(1'b0, 16'h0064);
      do_store(1'b1, 16'h0019);
      compute(OP_ADD, 3, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      chk("tp_add_result", 32'(result), 32'h007D);
      check_mem("tp_add");

      // Simultaneous go and store of B
      compute(OP_SUB, 2, 1'b0, 1'b0, 1'b1, 16'hFFF6, 1'b0, 1'b0, '0);
      check_mem("simul");

      // Store held across a compute is served right after it
      compute(OP_MUL, 4, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h1234);
      do_store(1'b0, 16'h1234);
      check_mem("held");

      // ALU error keeps previous result and skips the write
      compute(OP_ADD, 1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      check_mem("aerr");

      // Answer in the last allowed cycle, and immediate answer
      compute(OP_ADD, TIMEOUT - 1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      compute(OP_SUB, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      check_mem("edge");

      // Silent ALU -> watchdog
      compute(OP_DIV, 0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
      check_mem("wd");

      // Successful compute, then reset in WAIT_B
      compute(OP_ADD, 2, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      go = 1'b1; op = OP_SUB;
      tick;
      go = 1'b0;
      repeat (RD_LAT + 1) tick;
      tick;
      #3 reset = 1'b1;
      #1;
      exp_result = '0; exp_valid = 1'b0; exp_err = 1'b0;
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_en",   32'(bram_en), 0);
      chk("mrst_a",    32'(alu_a), 0);
      chk("mrst_b",    32'(alu_b), 0);
      check_status("mrst");
      @(posedge clk);
      #1 reset = 1'b0;
      tick;
      check_mem("mrst");
      $display("reset during WAIT_B busy=%0d", busy);
      compute(OP_SUB, 3, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      check_mem("post_rst");

      // Randomized transactions
      for (int it = 0; it < 12; it++) begin
         if ($urandom_range(0, 1) == 1) do_store(1'b0, DATA_W'($urandom));
         if ($urandom_range(0, 1) == 1) do_store(1'b1, DATA_W'($urandom));
         r_op  = 2'($urandom_range(0, 3));
         r_dly = int'($urandom_range(0, 6));
         r_err = ($urandom_range(0, 4) == 0);
         compute(r_op, r_dly, r_err, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
         check_mem("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_bram_sequencer.md
# operand_bram_sequencer

Controller that owns the calculator's single-port operand BRAM and sequences every access to it. It accepts operand writes from the button-driven input editor (A at address 0, B at address 1) and compute requests from the top level. For each compute it reads A and B back, drives the ALU through a start/done handshake, and writes the result to address 2. A watchdog aborts an ALU that never answers.

## Interface
Parameters:
- DATA_W, 16, operand/result width (two's complement)
- RD_LAT, 1, BRAM read latency in cycles (1 or 2)
- TIMEOUT, 1024, maximum cycles from alu_start to alu_done

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high
- store_req  in  1  editor requests an operand write; held until store_ack
- store_sel  in  1  0 = operand A (addr 0), 1 = operand B (addr 1)
- store_data  in  DATA_W  operand value; stable while store_req is high
- store_ack  out  1  one-cycle pulse; write is performed in this cycle
- go  in  1  one-cycle compute request
- op  in  2  ALU operation code; sampled in the cycle go is accepted
- bram_en, bram_we  out  1 each  BRAM enable and write enable
- bram_addr  out  2  0 = A, 1 = B, 2 = result
- bram_din  out  DATA_W  BRAM write data
- bram_dout  in  DATA_W  BRAM read data
- alu_start  out  1  one-cycle pulse
- alu_op  out  2  latched op
- alu_a, alu_b  out  DATA_W  operands; held from alu_start until done or abort
- alu_done  in  1  one-cycle completion pulse
- alu_result  in  DATA_W  valid with alu_done
- alu_err  in  1  overflow/invalid flag, valid with alu_done
- busy  out  1  high in every state except IDLE
- result  out  DATA_W  last successful result
- result_valid  out  1  level; high after a successful compute
- err  out  1  level; ALU error or watchdog timeout

## Operation
States:
- IDLE: waiting for a request.
- WR_OP: writes the operand and pulses store_ack.
- RD_A, WAIT_A: RD_A issues the read of A; WAIT_A lasts RD_LAT cycles and captures bram_dout in its last cycle.
- RD_B, WAIT_B: same sequence for B.
- EXEC: pulses alu_start.
- WAIT_ALU: waits for alu_done or timeout.
- WR_RES: writes the result to address 2.

Request handling:
- IDLE: store_req goes to WR_OP. Otherwise go (or go_pending) goes to RD_A and clears result_valid and err.
- go and store_req in the same IDLE cycle: the store wins and go_pending is set. The compute then runs on the newly stored operand.
- go arriving during WR_OP sets go_pending. go during any compute state is ignored.
- store_req during compute is not acked. The requester holds it and it is served on return to IDLE.

ALU completion:
- WAIT_ALU sees alu_done with alu_err=0: result is loaded, state goes to WR_RES, and result_valid is set the cycle after WR_RES.
- alu_done with alu_err=1: err=1, no BRAM write, result is unchanged, state goes to IDLE.
- Watchdog reaches TIMEOUT without alu_done: err=1, no write, state goes to IDLE. A late alu_done arriving in IDLE is ignored.

Outputs and arithmetic:
- bram_en is high only in WR_OP, RD_A, RD_B and WR_RES. bram_we is high only in WR_OP and WR_RES.
- No arithmetic in this block. Values pass through bit-exact; sign is never interpreted.

## Timing
- Reset value of all outputs is 0; state = IDLE; go_pending = 0. BRAM contents are untouched.
- Reset mid-operation aborts immediately. No write completes after reset asserts.
- Store path: store_req sampled high in IDLE at edge 0. Write and store_ack occur in cycle 1. Back in IDLE in cycle 2.
- Compute path with go accepted at edge 0:
  - Cycle 1: RD_A.
  - Cycle 2+RD_LAT: RD_B.
  - alu_start at cycle 3+2·RD_LAT (cycle 5 for RD_LAT=1).
  - alu_done at cycle d: WR_RES at d+1; result and result_valid visible from d+2.
- The watchdog counts cycles in WAIT_ALU. Timeout fires after exactly TIMEOUT cycles and takes the abort path in the next cycle.

## Structure
- A shared package holds:
  - state encoding;
  - address constants ADDR_A=0, ADDR_B=1, ADDR_RES=2;
  - the 2-bit op code enumeration (add, sub, mul, div), shared with the ALU and the input editor.
- One sub-module: alu_watchdog (clear, enable, timeout pulse; counter width $clog2(TIMEOUT+1)).

## Test plan
- Store then compute: store A=0x0064 and B=0x0019, then go with op=add, RD_LAT=1. Expect reads at addr 0 then 1, alu_a=100, alu_b=25, alu_start at cycle 5. ALU returns 125 → BRAM addr 2 written with 0x007D, result=125, result_valid=1.
- Simultaneous go and store_req (B=0xFFF6) in IDLE: store_ack in cycle 1, then compute starts with alu_b=0xFFF6.
- store_req held during compute: no store_ack until busy falls. Write occurs in the first WR_OP after IDLE.
- alu_err=1 with alu_done: err=1, result_valid=0, no write to addr 2, previous result retained.
- ALU silent with TIMEOUT=16: err=1 after 16 WAIT_ALU cycles, busy falls. A later alu_done is ignored.
- Reset asserted in WAIT_B: all outputs go to 0 asynchronously, no BRAM write occurs, and a subsequent compute works normally.
